// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the fetch/redirect stage: PC FSM states,
// instruction size and a target-alignment helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        FETCH  = 2'd1,
        PEND   = 2'd2
    } estado_pc_t;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic desalineado(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module contador_saturado #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cuenta
);

    logic [CNT_W-1:0] cuenta_q;
    logic [CNT_W-1:0] cuenta_d;

    // Next count, held once all-ones is reached.
    always_comb begin
        cuenta_d = cuenta_q;
        if (inc && (cuenta_q != {CNT_W{1'b1}})) begin
            cuenta_d = cuenta_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cuenta_d = cuenta_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= {CNT_W{1'b0}};
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule

// File: rtl/unidad_redireccion_pc.sv
// PC register and fetch-redirect stage: issues fetch requests over valid/ready,
// redirects on taken branches/jumps and squashes the wrong-path instructions.
module unidad_redireccion_pc
    import pipeline_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] PC_RESET = 32'h0000_0000,
    parameter int           CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             salto_ex,
    input  logic             rama_ex,
    input  logic             jump_ex,
    input  logic [W-1:0]     destino_ex,
    input  logic             stall,
    input  logic             imem_listo,
    output logic [W-1:0]     pc,
    output logic             pc_valido,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] cnt_redir,
    output logic             err_alineacion
);

    estado_pc_t     estado_q, estado_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   destino_pend_q, destino_pend_d;
    logic           pc_valido_q, pc_valido_d;
    logic           err_q, err_d;
    logic           redir_s;
    logic [W-1:0]   destino_al_s;
    logic           flush_if_id_s;
    logic           flush_id_ex_s;

    // Next-state, next-PC and flush decode.
    always_comb begin
        redir_s        = (rama_ex & salto_ex) | jump_ex;
        destino_al_s   = {destino_ex[W-1:2], 2'b00};
        estado_d       = estado_q;
        pc_d           = pc_q;
        destino_pend_d = destino_pend_q;
        flush_if_id_s  = 1'b0;
        flush_id_ex_s  = 1'b0;
        case (estado_q)
            INICIO: begin
                estado_d = FETCH;
                if (redir_s) begin
                    flush_if_id_s = 1'b1;
                    flush_id_ex_s = 1'b1;
                    pc_d          = destino_al_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            FETCH: begin
                if (redir_s) begin
                    flush_if_id_s = 1'b1;
                    flush_id_ex_s = 1'b1;
                    if (imem_listo) begin
                        pc_d = destino_al_s;
                    end else begin
                        destino_pend_d = destino_al_s;
                        estado_d       = PEND;
                    end
                end else if (imem_listo && !stall) begin
                    pc_d = pc_q + W'(INSTR_BYTES);
                end else begin
                    pc_d = pc_q;
                end
            end
            PEND: begin
                // A fresh redirect supersedes the pending target.
                if (redir_s) begin
                    flush_if_id_s = 1'b1;
                    flush_id_ex_s = 1'b1;
                    if (imem_listo) begin
                        pc_d     = destino_al_s;
                        estado_d = FETCH;
                    end else begin
                        destino_pend_d = destino_al_s;
                    end
                end else if (imem_listo) begin
                    flush_if_id_s = 1'b1;
                    pc_d          = destino_pend_q;
                    estado_d      = FETCH;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                estado_d = INICIO;
            end
        endcase
        pc_valido_d = (estado_d != INICIO);
        err_d       = err_q | (redir_s & desalineado(destino_ex[1:0]));
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= INICIO;
            pc_q           <= PC_RESET;
            destino_pend_q <= {W{1'b0}};
            pc_valido_q    <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            pc_q           <= pc_d;
            destino_pend_q <= destino_pend_d;
            pc_valido_q    <= pc_valido_d;
            err_q          <= err_d;
        end
    end

    contador_saturado #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (redir_s),
        .cuenta (cnt_redir)
    );

    assign pc             = pc_q;
    assign pc_valido      = pc_valido_q;
    assign flush_if_id    = flush_if_id_s;
    assign flush_id_ex    = flush_id_ex_s;
    assign err_alineacion = err_q;

endmodule
